// File: rtl/paper_seq_ctrl.sv
// Sequencer for the 2-bit paper processor: FETCH/EXEC/OPND/HALT FSM driving the
// instruction RAM address and owning pc, ir, accumulator, overflow and halt flag.
module paper_seq_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int ACC_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [1:0]            data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  ovf,
    output logic                  halted,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        OPND  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] OP_INC = 2'b00;
    localparam logic [1:0] OP_JNO = 2'b01;
    localparam logic [1:0] OP_HLT = 2'b10;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   pc;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   pc_skip;
    logic [1:0]              ir;
    logic [ACC_WIDTH:0]      acc_sum;

    // Increment with the carry-out kept in the top bit.
    function automatic logic [ACC_WIDTH:0] acc_inc(input logic [ACC_WIDTH-1:0] a);
        return {1'b0, a} + (ACC_WIDTH + 1)'(1);
    endfunction

    // The RAM word is only 2 bits wide; fit it to the address width.
    function automatic logic [ADDR_WIDTH-1:0] to_target(input logic [1:0] d);
        logic [ADDR_WIDTH+1:0] t;
        t = {{ADDR_WIDTH{1'b0}}, d};
        return t[ADDR_WIDTH-1:0];
    endfunction

    assign pc_inc  = pc + ADDR_WIDTH'(1);
    assign pc_skip = pc + ADDR_WIDTH'(2);
    assign acc_sum = acc_inc(acc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (run) state_d = EXEC;
            EXEC: begin
                unique case (ir)
                    OP_JNO:  state_d = OPND;
                    OP_HLT:  state_d = HALT;
                    default: state_d = FETCH;
                endcase
            end
            OPND:    state_d = FETCH;
            default: state_d = HALT;
        endcase
    end

    // addr depends only on state and pc, never on data.
    always_comb begin
        addr  = (state_q == OPND) ? pc_inc : pc;
        state = state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            ovf    <= 1'b0;
            halted <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: if (run) ir <= data;
                EXEC: begin
                    unique case (ir)
                        OP_INC: begin
                            acc <= acc_sum[ACC_WIDTH-1:0];
                            ovf <= acc_sum[ACC_WIDTH];
                            pc  <= pc_inc;
                        end
                        OP_JNO:  ;
                        OP_HLT:  halted <= 1'b1;
                        default: pc <= pc_inc;
                    endcase
                end
                // Jump on no overflow; otherwise skip over the operand word.
                OPND:    pc <= ovf ? pc_skip : to_target(data);
                default: ;
            endcase
        end
    end

endmodule
